pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the decode stage. It produces the stall and flush

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_load_scoreboard.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller:
// FSM state codes, scoreboard entry layout and the NOP encoding.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_MDU_WAIT = 2'd2,
        CTRL_BUS_HOLD = 2'd3
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] cnt;
    } sb_entry_t;

    function automatic logic reg_match(
        input logic       use_i,
        input logic [4:0] addr,
        input logic [4:0] rd
    );
        return use_i && (addr == rd) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_scoreboard.sv
// Single-entry load-use scoreboard: pending load rd plus a
// countdown of remaining stall cycles, and the ID source compare.
module load_scoreboard #(
    parameter int LOAD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_i,
    input  logic [4:0] set_rd_i,
    input  logic       dec_en_i,
    input  logic       valid_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       rs1_use_i,
    input  logic       rs2_use_i,
    output logic       hit_o
);
    import pipe_hazard_ctrl_pkg::*;

    sb_entry_t ent_q, ent_d;

    // The cycle the load leaves ID already counts toward LOAD_LAT.
    always_comb begin
        ent_d = ent_q;
        if (set_i) begin
            ent_d.rd  = set_rd_i;
            ent_d.cnt = 3'(LOAD_LAT - 1);
        end else if (dec_en_i && ent_q.cnt != 3'd0) begin
            ent_d.cnt = ent_q.cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ent_q <= '0;
        else      ent_q <= ent_d;
    end

    assign hit_o = valid_i && (ent_q.cnt != 3'd0) &&
                   (reg_match(rs1_use_i, rs1_i, ent_q.rd) ||
                    reg_match(rs2_use_i, rs2_i, ent_q.rd));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage sequencing controller: stall/flush for pc_reg,
// if_id and id_ex from load-use, jumps, MUL/DIV and bus hold.
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_use_i,
    input  logic        id_rs2_use_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_reg_wen_i,
    input  logic        id_is_load_i,
    input  logic        id_is_mdu_i,
    input  logic        ex_jump_en_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        mdu_done_i,
    input  logic        bus_hold_req_i,
    output logic        bus_hold_ack_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic [1:0]  state_o
);
    import pipe_hazard_ctrl_pkg::*;

    ctrl_state_e state_q, state_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        hit, run, jump, mdu_issue, ld_accept, sb_dec;

    assign run       = (state_q == CTRL_RUN);
    assign jump      = run && ex_jump_en_i;
    assign mdu_issue = run && id_valid_i && id_is_mdu_i && !hit;
    assign ld_accept = run && !jump && !hit && id_valid_i &&
                       id_is_load_i && id_reg_wen_i &&
                       (id_rd_addr_i != 5'd0);
    assign sb_dec    = run || (state_q == CTRL_FLUSH);

    load_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_i     (ld_accept),
        .set_rd_i  (id_rd_addr_i),
        .dec_en_i  (sb_dec),
        .valid_i   (id_valid_i),
        .rs1_i     (id_rs1_addr_i),
        .rs2_i     (id_rs2_addr_i),
        .rs1_use_i (id_rs1_use_i),
        .rs2_use_i (id_rs2_use_i),
        .hit_o     (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CTRL_RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            CTRL_RUN: begin
                if (jump) begin
                    state_d = CTRL_FLUSH;
                    fcnt_d  = 2'(FLUSH_CYCLES - 1);
                end else if (mdu_issue) begin
                    state_d = CTRL_MDU_WAIT;
                end else if (bus_hold_req_i) begin
                    state_d = CTRL_BUS_HOLD;
                end
            end
            CTRL_FLUSH: begin
                if (fcnt_q == 2'd0) state_d = CTRL_RUN;
                else                fcnt_d  = fcnt_q - 2'd1;
            end
            CTRL_MDU_WAIT: begin
                if (mdu_done_i) state_d = CTRL_RUN;
            end
            CTRL_BUS_HOLD: begin
                if (!bus_hold_req_i) state_d = CTRL_RUN;
            end
        endcase
    end

    // Gated by reset so outputs drop at once, whatever the inputs do.
    always_comb begin
        bus_hold_ack_o = 1'b0;
        hold_pc_o      = 1'b0;
        hold_if_id_o   = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        jump_en_o      = 1'b0;
        jump_addr_o    = 32'd0;
        if (rst) begin
            unique case (state_q)
                CTRL_RUN: begin
                    if (jump) begin
                        jump_en_o     = 1'b1;
                        jump_addr_o   = ex_jump_addr_i;
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (hit) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
                CTRL_FLUSH: begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
                CTRL_MDU_WAIT: begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                end
                CTRL_BUS_HOLD: begin
                    bus_hold_ack_o = 1'b1;
                    hold_pc_o      = 1'b1;
                    hold_if_id_o   = 1'b1;
                    flush_id_ex_o  = 1'b1;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues hand-computed
// output vectors, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        ack;
        logic        hpc;
        logic        hif;
        logic        fif;
        logic        fex;
        logic        jen;
        logic [31:0] ja;
        logic [1:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic        id_rs1_use_i, id_rs2_use_i, id_reg_wen_i;
    logic        id_is_load_i, id_is_mdu_i;
    logic        ex_jump_en_i;
    logic [31:0] ex_jump_addr_i;
    logic        mdu_done_i, bus_hold_req_i;
    logic        bus_hold_ack_o, hold_pc_o, hold_if_id_o;
    logic        flush_if_id_o, flush_id_ex_o, jump_en_o;
    logic [31:0] jump_addr_o;
    logic [1:0]  state_o;

    exp_t  q_exp[$];
    string q_nm[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs1_use_i   (id_rs1_use_i),
        .id_rs2_use_i   (id_rs2_use_i),
        .id_rd_addr_i   (id_rd_addr_i),
        .id_reg_wen_i   (id_reg_wen_i),
        .id_is_load_i   (id_is_load_i),
        .id_is_mdu_i    (id_is_mdu_i),
        .ex_jump_en_i   (ex_jump_en_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .mdu_done_i     (mdu_done_i),
        .bus_hold_req_i (bus_hold_req_i),
        .bus_hold_ack_o (bus_hold_ack_o),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .state_o        (state_o)
    );

    function automatic exp_t mk(logic ack, logic hpc, logic hif,
                                logic fif, logic fex, logic jen,
                                logic [31:0] ja, logic [1:0] st);
        exp_t e;
        e = '{ack, hpc, hif, fif, fex, jen, ja, st};
        return e;
    endfunction

    function automatic exp_t e_run();   return mk(0,0,0,0,0,0,32'd0,2'd0); endfunction
    function automatic exp_t e_stall(); return mk(0,1,1,0,1,0,32'd0,2'd0); endfunction
    function automatic exp_t e_flush(); return mk(0,0,0,1,1,0,32'd0,2'd1); endfunction
    function automatic exp_t e_mdu();   return mk(0,1,1,0,0,0,32'd0,2'd2); endfunction
    function automatic exp_t e_bus();   return mk(1,1,1,0,1,0,32'd0,2'd3); endfunction
    function automatic exp_t e_jump(logic [31:0] a);
        return mk(0,0,0,1,1,1,a,2'd0);
    endfunction

    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string n;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n = q_nm.pop_front();
            a = '{bus_hold_ack_o, hold_pc_o, hold_if_id_o, flush_if_id_o,
                  flush_id_ex_o, jump_en_o, jump_addr_o, state_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got ack=%b hpc=%b hif=%b fif=%b fex=%b jen=%b ja=%h st=%0d want ack=%b hpc=%b hif=%b fif=%b fex=%b jen=%b ja=%h st=%0d",
                         n, a.ack, a.hpc, a.hif, a.fif, a.fex, a.jen, a.ja, a.st,
                         e.ack, e.hpc, e.hif, e.fif, e.fex, e.jen, e.ja, e.st);
            end
        end
    end

    task automatic ins(logic v, logic [4:0] r1, logic [4:0] r2,
                       logic u1, logic u2, logic [4:0] rd,
                       logic wen, logic ld, logic mdu);
        id_valid_i    = v;
        id_rs1_addr_i = r1;
        id_rs2_addr_i = r2;
        id_rs1_use_i  = u1;
        id_rs2_use_i  = u2;
        id_rd_addr_i  = rd;
        id_reg_wen_i  = wen;
        id_is_load_i  = ld;
        id_is_mdu_i   = mdu;
    endtask

    task automatic nop_id();
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lw(logic [4:0] rd);
        ins(1, 0, 0, 0, 0, rd, 1, 1, 0);
    endtask

    task automatic alu(logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                       logic u1, logic u2);
        ins(1, r1, r2, u1, u2, rd, 1, 0, 0);
    endtask

    task automatic mdu_op();
        ins(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0, 1);
    endtask

    task automatic step(exp_t e, string nm);
        q_exp.push_back(e);
        q_nm.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        nop_id();
        ex_jump_en_i   = 1'b1;
        ex_jump_addr_i = 32'hdead_beef;
        mdu_done_i     = 1'b0;
        bus_hold_req_i = 1'b1;
        @(posedge clk);
        #1;
        step(e_run(), "reset_a");
        step(e_run(), "reset_b");
        rst            = 1'b1;
        ex_jump_en_i   = 1'b0;
        ex_jump_addr_i = 32'd0;
        bus_hold_req_i = 1'b0;
        step(e_run(), "idle");

        lw(5);                   step(e_run(),   "lw_x5");
        alu(6, 5, 1, 1, 1);      step(e_stall(), "ld_use_stall");
                                 step(e_run(),   "ld_use_issue");
        lw(0);                   step(e_run(),   "lw_x0");
        alu(6, 0, 1, 1, 1);      step(e_run(),   "x0_no_haz");
        alu(5, 1, 2, 1, 1);      step(e_run(),   "addi_x5");
        alu(6, 5, 1, 1, 1);      step(e_run(),   "alu_no_haz");
        lw(7);                   step(e_run(),   "lw_x7");
        alu(8, 1, 7, 1, 1);      step(e_stall(), "rs2_stall");
                                 step(e_run(),   "rs2_issue");
        lw(7);                   step(e_run(),   "lw_x7_b");
        alu(8, 1, 7, 1, 0);      step(e_run(),   "rs2_unused");

        lw(5);                   step(e_run(),   "t3_lw");
        alu(6, 5, 1, 1, 1);
        ex_jump_en_i   = 1'b1;
        ex_jump_addr_i = 32'h8000_0100;
        step(e_jump(32'h8000_0100), "jump_over_hit");
        ex_jump_addr_i = 32'h0000_1234;
        lw(9);                   step(e_flush(), "flush1_jmp_ign");
        ex_jump_en_i   = 1'b0;
        ex_jump_addr_i = 32'd0;
                                 step(e_flush(), "flush2");
        alu(6, 9, 5, 1, 1);      step(e_run(),   "post_flush");

        mdu_op();                step(e_run(),   "mdu_issue");
        nop_id();
        for (int j = 1; j <= 33; j++) begin
            bus_hold_req_i = (j >= 10);
            mdu_done_i     = (j == 33);
            step(e_mdu(), "mdu_wait");
        end
        mdu_done_i = 1'b0;       step(e_run(),   "mdu_back_run");
        bus_hold_req_i = 1'b0;   step(e_bus(),   "deferred_bus");
                                 step(e_run(),   "bus_exit");

        lw(5);
        bus_hold_req_i = 1'b1;   step(e_run(),   "ld_then_hold");
        alu(6, 5, 1, 1, 1);
        for (int j = 0; j < 4; j++) step(e_bus(), "hold_req_hi");
        bus_hold_req_i = 1'b0;   step(e_bus(),   "hold_req_fell");
                                 step(e_stall(), "frozen_ld_stall");
                                 step(e_run(),   "after_frozen");

        mdu_op();                step(e_run(),   "t6_mdu_issue");
        nop_id();                step(e_mdu(),   "t6_mdu_wait");
        rst = 1'b0;              step(e_run(),   "rst_in_mdu");
        rst = 1'b1;              step(e_run(),   "after_rst_mdu");
        lw(5);
        bus_hold_req_i = 1'b1;   step(e_run(),   "t6_ld_hold");
        nop_id();                step(e_bus(),   "t6_bus");
        rst = 1'b0;              step(e_run(),   "rst_in_bus");
        rst = 1'b1;
        bus_hold_req_i = 1'b0;
        alu(6, 5, 1, 1, 1);      step(e_run(),   "sb_cleared");
        nop_id();                step(e_run(),   "idle_end");

        for (int k = 0; k < 5 && q_exp.size() != 0; k++) @(negedge clk);
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
